// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// the derivation of the encoded grant-index width.
package rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   function automatic int calc_idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_if
   import rr_arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
);
   localparam int IDW = calc_idw(N);
   localparam int HCW = $clog2(MAX_HOLD + 1);

   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           busy;
   logic [HCW-1:0] hold_cnt;

   modport master (output req, input gnt, gnt_id, busy, hold_cnt);
   modport slave  (input req, output gnt, gnt_id, busy, hold_cnt);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or after i_start,
// wrapping modulo N. Rotate so i_start lands on bit 0, priority-encode, un-rotate.
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_start,
   output logic [IDW-1:0] o_winner,
   output logic           o_found
);
   localparam logic [IDW:0] NL = (IDW + 1)'(N);

   logic [N-1:0]   w_rot;
   logic [IDW:0]   w_lsh;
   logic [IDW-1:0] w_k;
   logic           w_any;
   logic [IDW:0]   w_sum;

   assign w_lsh = NL - {1'b0, i_start};
   assign w_rot = (i_req >> i_start) | (i_req << w_lsh);

   always_comb begin
      w_k   = '0;
      w_any = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_k   = IDW'(i);
            w_any = 1'b1;
         end
      end
   end

   assign w_sum    = {1'b0, i_start} + {1'b0, w_k};
   assign o_winner = (w_sum >= NL) ? IDW'(w_sum - NL) : w_sum[IDW-1:0];
   assign o_found  = w_any;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with hold limit: registered one-hot grant, held while the
// owner requests, forced to rotate after MAX_HOLD consecutive cycles.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic         clk,
   input  logic         rst,
   rr_arbiter_if.slave  bus
);
   localparam int             IDW  = calc_idw(N);
   localparam int             HCW  = $clog2(MAX_HOLD + 1);
   localparam logic [IDW-1:0] LAST = IDW'(N - 1);
   localparam logic [HCW-1:0] HMAX = HCW'(MAX_HOLD - 1);
   localparam logic [N-1:0]   ONE  = {{(N-1){1'b0}}, 1'b1};

   state_t         r_state, w_state_nxt;
   logic [N-1:0]   r_gnt, w_gnt_nxt;
   logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt;
   logic [IDW-1:0] r_last, w_last_nxt;
   logic [HCW-1:0] r_hold, w_hold_nxt;

   logic [IDW-1:0] w_start;
   logic [IDW-1:0] w_win;
   logic           w_found;
   logic           w_own_req;
   logic           w_timeout;

   // In GRANT the owner is always r_last, so one search from r_last+1 serves
   // both the idle pick and the release/timeout handoff.
   assign w_start = (r_last == LAST) ? '0 : r_last + 1'b1;

   rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .i_req    (bus.req),
      .i_start  (w_start),
      .o_winner (w_win),
      .o_found  (w_found)
   );

   assign w_own_req = |(bus.req & r_gnt);
   assign w_timeout = w_own_req && (r_hold == HMAX);

   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_gnt_id_nxt = r_gnt_id;
      w_last_nxt   = r_last;
      w_hold_nxt   = r_hold;
      case (r_state)
         ST_GRANT: begin
            if (w_own_req && !w_timeout) begin
               w_hold_nxt = r_hold + 1'b1;
            end else if (w_found) begin
               w_gnt_nxt    = ONE << w_win;
               w_gnt_id_nxt = w_win;
               w_last_nxt   = w_win;
               w_hold_nxt   = '0;
            end else begin
               w_state_nxt  = ST_IDLE;
               w_gnt_nxt    = '0;
               w_gnt_id_nxt = '0;
               w_hold_nxt   = '0;
            end
         end
         default: begin
            w_gnt_nxt    = '0;
            w_gnt_id_nxt = '0;
            w_hold_nxt   = '0;
            if (w_found) begin
               w_state_nxt  = ST_GRANT;
               w_gnt_nxt    = ONE << w_win;
               w_gnt_id_nxt = w_win;
               w_last_nxt   = w_win;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_last   <= LAST;
         r_hold   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_gnt_id <= w_gnt_id_nxt;
         r_last   <= w_last_nxt;
         r_hold   <= w_hold_nxt;
      end
   end

   assign bus.gnt      = r_gnt;
   assign bus.gnt_id   = r_gnt_id;
   assign bus.busy     = |r_gnt;
   assign bus.hold_cnt = r_hold;
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter (N=4, MAX_HOLD=8): hand-derived vector table for the
// directed scenarios, then a randomized phase checked against a reference model.
module tb_rr_arbiter;
   localparam int N  = 4;
   localparam int MH = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rr_arbiter_if #(.N(N), .MAX_HOLD(MH)) bus ();

   rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic [3:0] hold;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                      input int id, input int h);
      vec_t v;
      v.rst  = r;
      v.req  = rq;
      v.gnt  = g;
      v.id   = 2'(id);
      v.hold = 4'(h);
      tbl.push_back(v);
   endtask

   task automatic check(input string nm, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%0h expected=%0h", nm, idx, act, exp);
      end
   endtask

   // Drive one step away from the active edge, then compare just after it.
   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      @(negedge clk);
      rst     = v.rst;
      bus.req = v.req;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("gnt", idx, int'(bus.gnt), int'(e.gnt));
      check("busy", idx, int'(bus.busy), int'(e.gnt != 4'b0));
      check("hold_cnt", idx, int'(bus.hold_cnt), int'(e.hold));
      if (e.rst || e.gnt != 4'b0)
         check("gnt_id", idx, int'(bus.gnt_id), int'(e.id));
   endtask

   function automatic int scan(input logic [3:0] r, input int start);
      for (int k = 0; k < N; k++) begin
         if (r[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   initial begin
      int   mb, mid, ml, mh, w;
      logic [3:0] rq;
      vec_t v;

      rst     = 1'b1;
      bus.req = '0;

      // reset, then first grant one edge after release
      add(1, 4'b1111, 4'b0000, 0, 0);
      add(1, 4'b1111, 4'b0000, 0, 0);
      add(0, 4'b1111, 4'b0001, 0, 0);
      // rotation with zero-bubble handoff 0,1,2,3,0
      add(0, 4'b1110, 4'b0010, 1, 0);
      add(0, 4'b1101, 4'b0100, 2, 0);
      add(0, 4'b1011, 4'b1000, 3, 0);
      add(0, 4'b0111, 4'b0001, 0, 0);
      add(0, 4'b0000, 4'b0000, 0, 0);
      // single requester, hold counting, drop
      add(0, 4'b0100, 4'b0100, 2, 0);
      add(0, 4'b0100, 4'b0100, 2, 1);
      add(0, 4'b0100, 4'b0100, 2, 2);
      add(0, 4'b0000, 4'b0000, 0, 0);
      // timeout fairness between 0 and 1
      add(0, 4'b0011, 4'b0001, 0, 0);
      for (int k = 1; k < MH; k++) add(0, 4'b0011, 4'b0001, 0, k);
      add(0, 4'b0011, 4'b0010, 1, 0);
      for (int k = 1; k < MH; k++) add(0, 4'b0011, 4'b0010, 1, k);
      add(0, 4'b0011, 4'b0001, 0, 0);
      // solo requester re-granted on timeout, hold_cnt wraps 7 -> 0
      for (int k = 1; k < MH; k++) add(0, 4'b0001, 4'b0001, 0, k);
      add(0, 4'b0001, 4'b0001, 0, 0);
      add(0, 4'b0001, 4'b0001, 0, 1);
      add(0, 4'b0000, 4'b0000, 0, 0);
      // wrap-around search
      add(0, 4'b1000, 4'b1000, 3, 0);
      add(0, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b1010, 4'b0010, 1, 0);
      add(0, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b0011, 4'b0001, 0, 0);
      add(0, 4'b0010, 4'b0010, 1, 0);
      add(0, 4'b0000, 4'b0000, 0, 0);
      // reset mid-grant at hold_cnt=5
      add(0, 4'b0100, 4'b0100, 2, 0);
      for (int k = 1; k <= 5; k++) add(0, 4'b0100, 4'b0100, 2, k);
      add(1, 4'b0100, 4'b0000, 0, 0);
      add(0, 4'b0100, 4'b0100, 2, 0);
      add(0, 4'b0100, 4'b0100, 2, 1);
      // pointer returns to N-1 on reset: requester 0 beats 2
      add(1, 4'b0100, 4'b0000, 0, 0);
      add(0, 4'b0101, 4'b0001, 0, 0);

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // randomized phase against a reference model
      mb = 0; mid = 0; ml = N - 1; mh = 0;
      rq = 4'b0000;
      for (int i = 0; i < 600; i++) begin
         v.rst = (i == 0) || ($urandom_range(0, 59) == 0);
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
         v.req = rq;
         if (v.rst) begin
            mb = 0; mid = 0; mh = 0; ml = N - 1;
         end else if (mb == 0) begin
            w = scan(rq, (ml + 1) % N);
            if (w >= 0) begin mb = 1; mid = w; ml = w; mh = 0; end
         end else if (rq[mid] && mh < MH - 1) begin
            mh++;
         end else begin
            w = scan(rq, (mid + 1) % N);
            if (w >= 0) begin mid = w; ml = w; mh = 0; end
            else begin mb = 0; mid = 0; mh = 0; end
         end
         v.gnt  = (mb != 0) ? (4'b0001 << mid) : 4'b0000;
         v.id   = 2'(mid);
         v.hold = 4'(mh);
         apply(v, 1000 + i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one gate-level resource (e.g. a shared or/and output stage) between N requesters.
- Issues a registered one-hot grant and holds it while the owner keeps requesting.
- A hold limit forces rotation, so no requester can starve the others.
- Sits between requester logic and the shared primitive; busy is the OR-reduction of the grant vector.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (>=1).
- IDW, $clog2(N), width of the encoded grant index (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request level; bit i high = requester i wants the resource.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_id  output  IDW  index of the current owner; valid only when busy=1.
- busy  output  1  high when any gnt bit is set (OR of gnt).
- hold_cnt  output  $clog2(MAX_HOLD+1)  cycles the current owner has held the grant, minus 1.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst; all state updates on posedge clk.
- Reset (rst=1 at an edge):
  - Outputs: gnt=0, gnt_id=0, busy=0, hold_cnt=0.
  - Internal: last-owner pointer = N-1 (requester 0 has first priority); state=IDLE.
  - Reset mid-grant drops the grant on that edge; no partial hold survives.
- States: IDLE (no owner), GRANT (owner held in gnt_id).
- Priority search: scan from (last+1) mod N upward with wrap-around; the first set req bit wins. The owner just released or timed out is therefore scanned last.
- IDLE:
  - If req!=0, go to GRANT. Set gnt/gnt_id to the search winner, last=winner, hold_cnt=0.
  - Latency from req assertion to gnt is exactly 1 cycle.
  - If req=0, stay IDLE with outputs 0.
- GRANT, each edge:
  - Release: req[gnt_id]=0.
  - Timeout: req[gnt_id]=1 and hold_cnt==MAX_HOLD-1.
  - Neither: keep the owner, hold_cnt+1.
  - Release or timeout: re-run the search on the current req, starting at owner+1.
    - Winner found: grant it in the same edge (zero-bubble handoff) and clear hold_cnt.
    - No winner: go to IDLE, gnt=0.
  - On timeout with no other requester, the search returns the owner itself. It is re-granted with hold_cnt=0 (grant stays continuously high).
- Requests are levels. The arbiter never drops a grant while the owner requests, except at timeout.
- Grant is always one-hot or zero; gnt_id matches the set bit.
- Simultaneous release by the owner and new requests from others: handoff on that edge per the search order.
- X on req is not filtered; the bench drives known values after reset.
- hold_cnt saturates logic-wise at MAX_HOLD-1, because timeout fires there.

Decomposition:
- Shared package holds:
  - state encoding constants (ST_IDLE=0, ST_GRANT=1);
  - a function computing IDW from N.
- One natural sub-module: rr_pick.
  - Combinational: inputs req[N], start index.
  - Outputs: winner index, found flag.
  - Implemented as a rotate, priority-encode and un-rotate.
  - Used for both the IDLE and GRANT searches.
- The remaining FSM, counter and output registers live in rr_arbiter.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req=4'b1111, then rst=0 → gnt=0, busy=0 during reset. First edge after release gives gnt=4'b0001, gnt_id=0.
- Single requester: req=4'b0100 → gnt=4'b0100 one cycle later, hold_cnt counts 0,1,2… Drop req → gnt=0, busy=0 on the next edge.
- Rotation: req=4'b1111, each owner drops its req for one cycle after being granted → grant order 0,1,2,3,0. Zero bubble between grants.
- Timeout fairness: MAX_HOLD=8, req=4'b0011 held constant → owner 0 holds for 8 cycles, then 1 for 8, then 0. Solo req=4'b0001 held → gnt stays 4'b0001 and hold_cnt wraps 7→0.
- Wrap-around search: last=3 after granting 3, req=4'b1010 → next grant is 1. With last=1 and req=4'b0011 → next grant is 0.
- Reset mid-grant: owner 2 at hold_cnt=5, assert rst for 1 cycle → gnt=0 next edge. After reset, req=4'b0100 → gnt=4'b0100 with hold_cnt=0.
